// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared state, select encodings and ALU decode for mc_control_fsm
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  // Immediate formats understood by the extend unit
  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;
  localparam logic [1:0] IMM_SH  = 2'b11;

  // ALU operations
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // Result mux
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // ALU operand muxes
  localparam logic [1:0] SRCA_RN   = 2'b00;
  localparam logic [1:0] SRCA_PC   = 2'b10;
  localparam logic [1:0] SRCB_RM   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Data-processing cmd field -> {nowrite, alu op}; CMP is a SUB that skips write-back
  function automatic logic [2:0] alu_decode(input logic [3:0] cmd);
    logic [2:0] r;
    case (cmd)
      4'b0100: r = {1'b0, ALU_ADD};
      4'b0010: r = {1'b0, ALU_SUB};
      4'b0000: r = {1'b0, ALU_AND};
      4'b1100: r = {1'b0, ALU_ORR};
      4'b1010: r = {1'b1, ALU_SUB};
      default: r = {1'b0, ALU_ADD};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mc_control_fsm_cond_check.sv
// rtl/mc_control_fsm_cond_check.sv - NZCV flags register and condition-code evaluation
module cond_check (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       flag_load,
  output logic       cond_ex
);

  logic [3:0] flags_q;
  logic       n_f, z_f, c_f, v_f;

  assign {n_f, z_f, c_f, v_f} = flags_q;

  // Flags only change when the controller asks for a load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else if (flag_load) begin
      flags_q <= alu_flags;
    end
  end

  // Evaluate the instruction condition against the stored flags
  always_comb begin
    cond_ex = 1'b1;
    case (cond)
      4'b0000: cond_ex = z_f;
      4'b0001: cond_ex = ~z_f;
      4'b0010: cond_ex = c_f;
      4'b0011: cond_ex = ~c_f;
      4'b0100: cond_ex = n_f;
      4'b0101: cond_ex = ~n_f;
      4'b0110: cond_ex = v_f;
      4'b0111: cond_ex = ~v_f;
      4'b1000: cond_ex = c_f & ~z_f;
      4'b1001: cond_ex = ~c_f | z_f;
      4'b1010: cond_ex = (n_f == v_f);
      4'b1011: cond_ex = (n_f != v_f);
      4'b1100: cond_ex = ~z_f & (n_f == v_f);
      4'b1101: cond_ex = z_f | (n_f != v_f);
      default: cond_ex = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle controller stepping one instruction through 2-5 states
module mc_control_fsm
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cond,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic [3:0] alu_flags,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [1:0] alu_control
);

  state_t     state_q, state_d;
  logic       cond_ex;
  logic       flag_load;
  logic       nowrite;
  logic [1:0] dp_alu;
  logic       rd_is_pc;
  logic       pc_write_c, mem_write_c, ir_write_c, reg_write_c;

  assign {nowrite, dp_alu} = alu_decode(funct[4:1]);
  assign rd_is_pc          = (rd == 4'd15);

  // Flags capture ALU output on the edge leaving an execute state of a setting, passing instruction
  assign flag_load = ((state_q == S_EXECR) || (state_q == S_EXECI)) && funct[0] && cond_ex;

  cond_check u_cond_check (
    .clk       (clk),
    .rst_n     (rst_n),
    .cond      (cond),
    .alu_flags (alu_flags),
    .flag_load (flag_load),
    .cond_ex   (cond_ex)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-state datapath controls
  always_comb begin
    state_d     = S_FETCH;
    pc_write_c  = 1'b0;
    adr_src     = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_RN;
    alu_src_b   = SRCB_RM;
    imm_src     = IMM_DP;
    alu_control = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        state_d     = S_DECODE;
        ir_write_c  = 1'b1;
        pc_write_c  = 1'b1;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_FOUR;
        result_src  = RES_ALU;
      end
      S_DECODE: begin
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        case (op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        state_d     = funct[0] ? S_MEMRD : S_MEMWR;
        alu_src_b   = SRCB_IMM;
        imm_src     = IMM_MEM;
        alu_control = funct[3] ? ALU_ADD : ALU_SUB;
      end
      S_MEMRD: begin
        state_d = S_MEMWB;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        state_d     = S_FETCH;
        result_src  = RES_MEM;
        reg_write_c = cond_ex;
        pc_write_c  = cond_ex & rd_is_pc;
      end
      S_MEMWR: begin
        state_d     = S_FETCH;
        adr_src     = 1'b1;
        mem_write_c = cond_ex;
      end
      S_EXECR: begin
        state_d     = S_ALUWB;
        alu_src_b   = SRCB_RM;
        imm_src     = IMM_SH;
        alu_control = dp_alu;
      end
      S_EXECI: begin
        state_d     = S_ALUWB;
        alu_src_b   = SRCB_IMM;
        imm_src     = IMM_DP;
        alu_control = dp_alu;
      end
      S_ALUWB: begin
        state_d     = S_FETCH;
        reg_write_c = cond_ex & ~nowrite;
        pc_write_c  = cond_ex & ~nowrite & rd_is_pc;
      end
      S_BRANCH: begin
        state_d     = S_FETCH;
        alu_src_b   = SRCB_IMM;
        imm_src     = IMM_BR;
        result_src  = RES_ALU;
        pc_write_c  = cond_ex;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Architectural write enables are held off for the whole time reset is asserted
  assign pc_write  = pc_write_c  & rst_n;
  assign mem_write = mem_write_c & rst_n;
  assign ir_write  = ir_write_c  & rst_n;
  assign reg_write = reg_write_c & rst_n;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - table-driven bench for mc_control_fsm
module tb_mc_control_fsm;

  logic       clk;
  logic       rst_n;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] alu_flags;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src, alu_control;

  mc_control_fsm dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cond        (cond),
    .op          (op),
    .funct       (funct),
    .rd          (rd),
    .alu_flags   (alu_flags),
    .pc_write    (pc_write),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .reg_write   (reg_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .imm_src     (imm_src),
    .alu_control (alu_control)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic [3:0]  flags;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_bad;

  // {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, alu_src_a, alu_src_b, imm_src, alu_control}
  function automatic logic [14:0] mk(input logic pc, adr, mw, ir, rw,
                                     input logic [1:0] rs, sa, sb, imm, alu);
    return {pc, adr, mw, ir, rw, rs, sa, sb, imm, alu};
  endfunction

  function automatic logic [14:0] outs();
    return {pc_write, adr_src, mem_write, ir_write, reg_write,
            result_src, alu_src_a, alu_src_b, imm_src, alu_control};
  endfunction

  logic [14:0] e_f, e_d, e_rd;

  function automatic logic [14:0] ma(input logic [1:0] alu); return mk(0,0,0,0,0,2'd0,2'd0,2'd1,2'd1,alu); endfunction
  function automatic logic [14:0] wb(input logic rw, pc);     return mk(pc,0,0,0,rw,2'd1,2'd0,2'd0,2'd0,2'd0); endfunction
  function automatic logic [14:0] mw(input logic w);          return mk(0,1,w,0,0,2'd0,2'd0,2'd0,2'd0,2'd0); endfunction
  function automatic logic [14:0] er(input logic [1:0] alu); return mk(0,0,0,0,0,2'd0,2'd0,2'd0,2'd3,alu); endfunction
  function automatic logic [14:0] ei(input logic [1:0] alu); return mk(0,0,0,0,0,2'd0,2'd0,2'd1,2'd0,alu); endfunction
  function automatic logic [14:0] aw(input logic rw, pc);     return mk(pc,0,0,0,rw,2'd0,2'd0,2'd0,2'd0,2'd0); endfunction
  function automatic logic [14:0] br(input logic pc);         return mk(pc,0,0,0,0,2'd2,2'd0,2'd1,2'd2,2'd0); endfunction

  // One instruction: FETCH, DECODE, then up to three more rows; af is driven only in row 2
  task automatic ins(input string nm, input logic [3:0] c, input logic [1:0] o,
                     input logic [5:0] f, input logic [3:0] r, input logic [3:0] af,
                     input int n, input logic [14:0] e2, e3, e4);
    logic [14:0] ex [5];
    ex[0] = e_f; ex[1] = e_d; ex[2] = e2; ex[3] = e3; ex[4] = e4;
    for (int i = 0; i < n; i++) begin
      vec_t v;
      v.name  = $sformatf("%s.c%0d", nm, i);
      v.cond  = c;
      v.op    = o;
      v.funct = f;
      v.rd    = r;
      v.flags = (i == 2) ? af : ~af;
      v.exp   = ex[i];
      vecs.push_back(v);
    end
  endtask

  task automatic check(input string nm, input logic [14:0] exp);
    n_vec++;
    if (outs() !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, outs(), exp);
    end
  endtask

  // Drive a row, check mid-cycle, then advance one state
  task automatic do_vec(input vec_t v);
    cond      = v.cond;
    op        = v.op;
    funct     = v.funct;
    rd        = v.rd;
    alu_flags = v.flags;
    @(negedge clk);
    check(v.name, v.exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    e_f  = mk(1,0,0,1,0,2'd2,2'd2,2'd2,2'd0,2'd0);
    e_d  = mk(0,0,0,0,0,2'd2,2'd2,2'd2,2'd0,2'd0);
    e_rd = mk(0,1,0,0,0,2'd0,2'd0,2'd0,2'd0,2'd0);

    ins("ldr",     4'hE, 2'b01, 6'b011001, 4'd3,  4'h0, 5, ma(0), e_rd, wb(1,0));
    ins("ldr_pc",  4'hE, 2'b01, 6'b011001, 4'd15, 4'h0, 5, ma(0), e_rd, wb(1,1));
    ins("str_u0",  4'hE, 2'b01, 6'b010000, 4'd4,  4'h0, 4, ma(1), mw(1), 15'd0);
    ins("subs_r",  4'hE, 2'b00, 6'b000101, 4'd2,  4'h4, 4, er(1), aw(1,0), 15'd0);
    ins("beq_z",   4'h0, 2'b10, 6'b000000, 4'd0,  4'h0, 3, br(1), 15'd0, 15'd0);
    ins("bne_z",   4'h1, 2'b10, 6'b000000, 4'd0,  4'h0, 3, br(0), 15'd0, 15'd0);
    ins("adds_i0", 4'hE, 2'b00, 6'b101001, 4'd1,  4'h0, 4, ei(0), aw(1,0), 15'd0);
    ins("beq_nz",  4'h0, 2'b10, 6'b000000, 4'd0,  4'h0, 3, br(0), 15'd0, 15'd0);
    ins("subseq",  4'h0, 2'b00, 6'b000101, 4'd2,  4'h4, 4, er(1), aw(0,0), 15'd0);
    ins("beq_kept",4'h0, 2'b10, 6'b000000, 4'd0,  4'h0, 3, br(0), 15'd0, 15'd0);
    ins("add_pc",  4'hE, 2'b00, 6'b101000, 4'd15, 4'h0, 4, ei(0), aw(1,1), 15'd0);
    ins("cmp",     4'hE, 2'b00, 6'b010101, 4'd15, 4'h4, 4, er(1), aw(0,0), 15'd0);
    ins("beq_cmp", 4'h0, 2'b10, 6'b000000, 4'd0,  4'h0, 3, br(1), 15'd0, 15'd0);
    ins("bge",     4'hA, 2'b10, 6'b000000, 4'd0,  4'h0, 3, br(1), 15'd0, 15'd0);
    ins("and_r",   4'hE, 2'b00, 6'b000000, 4'd5,  4'h0, 4, er(2), aw(1,0), 15'd0);
    ins("orr_i",   4'hE, 2'b00, 6'b111000, 4'd6,  4'h0, 4, ei(3), aw(1,0), 15'd0);
    ins("eor_add", 4'hE, 2'b00, 6'b000010, 4'd7,  4'h0, 4, er(0), aw(1,0), 15'd0);
    ins("unsup",   4'hE, 2'b11, 6'b000000, 4'd0,  4'h0, 2, 15'd0, 15'd0, 15'd0);
    ins("adds_n",  4'hE, 2'b00, 6'b101001, 4'd1,  4'h8, 4, ei(0), aw(1,0), 15'd0);
    ins("blt",     4'hB, 2'b10, 6'b000000, 4'd0,  4'h0, 3, br(1), 15'd0, 15'd0);
    ins("bgt",     4'hC, 2'b10, 6'b000000, 4'd0,  4'h0, 3, br(0), 15'd0, 15'd0);
    ins("bmi",     4'h4, 2'b10, 6'b000000, 4'd0,  4'h0, 3, br(1), 15'd0, 15'd0);
    ins("bls",     4'h9, 2'b10, 6'b000000, 4'd0,  4'h0, 3, br(1), 15'd0, 15'd0);
    ins("cmp2",    4'hE, 2'b00, 6'b010101, 4'd0,  4'h4, 4, er(1), aw(0,0), 15'd0);

    rst_n = 1'b0; cond = 4'hE; op = 2'b00; funct = 6'd0; rd = 4'd0; alu_flags = 4'h0;
    @(negedge clk);
    check("reset_hold", e_d);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (vecs[i]) do_vec(vecs[i]);

    // LDR into MEMRD, then reset asynchronously mid-cycle
    begin
      vec_t v;
      v.cond = 4'hE; v.op = 2'b01; v.funct = 6'b011001; v.rd = 4'd15; v.flags = 4'h0;
      v.name = "rst_ldr.c0"; v.exp = e_f;   do_vec(v);
      v.name = "rst_ldr.c1"; v.exp = e_d;   do_vec(v);
      v.name = "rst_ldr.c2"; v.exp = ma(0); do_vec(v);
      #1;
      check("in_memrd", e_rd);
      rst_n = 1'b0;
      #1;
      check("rst_async", e_d);
      @(posedge clk);
      #1;
      check("rst_held", e_d);
      rst_n = 1'b1;
      v.name = "rel_fetch"; v.exp = e_f; do_vec(v);
      v.cond = 4'h0; v.op = 2'b10; v.funct = 6'd0; v.rd = 4'd0;
      v.name = "rel_beq.c1"; v.exp = e_d;   do_vec(v);
      v.name = "rel_beq.c2"; v.exp = br(0); do_vec(v);
      v.name = "rel_back";   v.exp = e_f;   do_vec(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
